// File: rtl/sdm_ctrl_pkg.sv
// Shared types for the SDM loopback burst controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sdm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PUSH,
    ACK,
    CAPT,
    OUT,
    FIN
  } sdm_ctrl_st_e;

  // The SDM handshakes are toggle-based: an event is a change of level.
  function automatic logic tgl(input logic x);
    return ~x;
  endfunction

endpackage

// File: rtl/sdm_lvl_edge.sv
// Registers a level once and reports its rising/falling edges against the live input.
// Latency: q lags lvl by 1 cycle; rise/fall are combinational from {q, lvl}.
// Backpressure: none.
// Ports: clk, rstn (async active-low), lvl (live level), q (registered level),
//        rise (q==0 && lvl==1), fall (q==1 && lvl==0).
module sdm_lvl_edge (
  input  logic clk,
  input  logic rstn,
  input  logic lvl,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= 1'b0;
    else       q <= lvl;
  end

  assign rise = ~q & lvl;
  assign fall = q & ~lvl;

endmodule

// File: rtl/sdm_burst_ctrl.sv
// Sequences an sdm_tx/sdm_rx loopback pair through bursts of len samples, stream in to stream out.
// Latency: one sample in flight at a time; each step waits on the SDM pair (toggle handshakes).
// Backpressure: s_ready only in LOAD; m_valid held with stable m_data until m_ready; LOAD/OUT never time out.
// Ports: clk, rstn | start, abort, len, busy, done, err | s_valid/s_ready/s_data |
//        m_valid/m_ready/m_data | sdm_setn, tx_push/tx_clear/tx_wdata/tx_empty, rx_pop/rx_clear/rx_rdata/rx_full
module sdm_burst_ctrl
  import sdm_ctrl_pkg::*;
#(
  parameter int DMSB = 3,
  parameter int LMSB = 7,
  parameter int TMSB = 11,
  parameter int TMO  = 2000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [LMSB:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DMSB:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DMSB:0] m_data,
  output logic          sdm_setn,
  output logic          tx_push,
  output logic          tx_clear,
  output logic [DMSB:0] tx_wdata,
  input  logic          tx_empty,
  output logic          rx_pop,
  output logic          rx_clear,
  input  logic [DMSB:0] rx_rdata,
  input  logic          rx_full
);

  localparam logic [TMSB:0] TMO_W = (TMSB+1)'(TMO);

  sdm_ctrl_st_e  state, state_n;
  logic [LMSB:0] cnt, cnt_n;
  logic [TMSB:0] wdog, wdog_n;
  logic          err_n, zdone_q, zdone_n, setn_n;
  logic          tx_push_n, tx_clear_n, rx_pop_n, rx_clear_n;
  logic [DMSB:0] tx_wdata_n, m_data_n;
  logic          timed;

  logic empty_q, tx_rise, tx_fall;
  logic full_q, full_rise, full_fall;

  sdm_lvl_edge u_empty (
    .clk  (clk),
    .rstn (rstn),
    .lvl  (tx_empty),
    .q    (empty_q),
    .rise (tx_rise),
    .fall (tx_fall)
  );

  sdm_lvl_edge u_full (
    .clk  (clk),
    .rstn (rstn),
    .lvl  (rx_full),
    .q    (full_q),
    .rise (full_rise),
    .fall (full_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{tx_rise, tx_fall, full_q, full_fall};

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    err_n      = err;
    zdone_n    = 1'b0;
    setn_n     = sdm_setn;
    tx_push_n  = tx_push;
    tx_clear_n = tx_clear;
    rx_pop_n   = rx_pop;
    rx_clear_n = rx_clear;
    tx_wdata_n = tx_wdata;
    m_data_n   = m_data;
    timed      = state inside {PUSH, ACK, CAPT};

    case (state)
      IDLE: begin
        // abort wins over a coincident start
        if (start && !abort) begin
          if (len == '0) begin
            zdone_n = 1'b1;
          end else begin
            cnt_n   = len;
            err_n   = 1'b0;
            setn_n  = 1'b1;
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          tx_wdata_n = s_data;
          state_n    = PUSH;
        end
      end
      PUSH: begin
        if (empty_q) begin
          tx_push_n = tgl(tx_push);
          state_n   = ACK;
        end
      end
      ACK: begin
        if (!empty_q) state_n = CAPT;
      end
      CAPT: begin
        // only a fresh word counts, never a stale full level
        if (full_rise) begin
          m_data_n = rx_rdata;
          rx_pop_n = tgl(rx_pop);
          state_n  = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          cnt_n   = cnt - (LMSB+1)'(1);
          state_n = (cnt == (LMSB+1)'(1)) ? FIN : LOAD;
        end
      end
      FIN: begin
        setn_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Cancel paths override whatever the step above decided.
    if (state != IDLE && (abort || (timed && wdog == TMO_W))) begin
      if (!abort) err_n = 1'b1;
      cnt_n      = cnt;
      tx_push_n  = tx_push;
      rx_pop_n   = rx_pop;
      m_data_n   = m_data;
      tx_clear_n = tgl(tx_clear);
      rx_clear_n = tgl(rx_clear);
      setn_n     = 1'b0;
      state_n    = IDLE;
    end

    if (state_n != state) wdog_n = '0;
    else if (timed)       wdog_n = wdog + (TMSB+1)'(1);
    else                  wdog_n = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      wdog     <= '0;
      err      <= 1'b0;
      zdone_q  <= 1'b0;
      sdm_setn <= 1'b0;
      tx_push  <= 1'b0;
      tx_clear <= 1'b0;
      rx_pop   <= 1'b0;
      rx_clear <= 1'b0;
      tx_wdata <= '0;
      m_data   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wdog     <= wdog_n;
      err      <= err_n;
      zdone_q  <= zdone_n;
      sdm_setn <= setn_n;
      tx_push  <= tx_push_n;
      tx_clear <= tx_clear_n;
      rx_pop   <= rx_pop_n;
      rx_clear <= rx_clear_n;
      tx_wdata <= tx_wdata_n;
      m_data   <= m_data_n;
    end
  end

  assign busy    = (state != IDLE);
  assign s_ready = (state == LOAD);
  assign m_valid = (state == OUT);
  assign done    = (state == FIN) | zdone_q;

endmodule

// File: tb/tb_sdm_burst_ctrl.sv
module tb_sdm_burst_ctrl;
  localparam int DMSB = 3, LMSB = 7, TMSB = 11, TMO = 50;

  logic clk = 1'b0;
  logic rstn, start, abort, busy, done, err;
  logic [LMSB:0] len;
  logic s_valid, s_ready, m_valid, m_ready;
  logic signed [DMSB:0] s_data, m_data, tx_wdata, rx_rdata;
  logic sdm_setn, tx_push, tx_clear, tx_empty, rx_pop, rx_clear, rx_full;

  always #5 clk = ~clk;

  sdm_burst_ctrl #(.DMSB(DMSB), .LMSB(LMSB), .TMSB(TMSB), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .len(len),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .sdm_setn(sdm_setn), .tx_push(tx_push), .tx_clear(tx_clear), .tx_wdata(tx_wdata),
    .tx_empty(tx_empty), .rx_pop(rx_pop), .rx_clear(rx_clear), .rx_rdata(rx_rdata),
    .rx_full(rx_full)
  );

  int checks = 0, errors = 0;
  int push_cnt = 0, pop_cnt = 0, done_cnt = 0, out_cnt = 0, txc_cnt = 0, rxc_cnt = 0;
  int setn_hi = 0, setn_bad = 0;
  int s_push, s_pop, s_done, s_out, s_txc, s_rxc, s_setn;
  logic signed [DMSB:0] exp_q[$];
  logic signed [DMSB:0] smp[$];
  bit stall = 0, rand_ready = 1, bp_arm = 0;
  int fix_dly = 0;
  int exp_err = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loopback SDM pair: accepts a pushed word, returns it on rx after a few cycles.
  initial begin
    logic l_push, l_pop, l_txc, l_rxc, pend;
    logic signed [DMSB:0] word;
    int dly;
    tx_empty = 1'b1; rx_full = 1'b0; rx_rdata = '0;
    l_push = 0; l_pop = 0; l_txc = 0; l_rxc = 0; pend = 0; word = '0; dly = 0;
    forever begin
      @(posedge clk); #2;
      if (!rstn) begin
        l_push = 0; l_pop = 0; l_txc = 0; l_rxc = 0; pend = 0;
        tx_empty = 1'b1; rx_full = 1'b0;
        continue;
      end
      if (tx_clear != l_txc) begin l_txc = tx_clear; pend = 0; tx_empty = 1'b1; end
      if (rx_clear != l_rxc) begin l_rxc = rx_clear; pend = 0; rx_full = 1'b0; end
      if (rx_pop != l_pop) begin l_pop = rx_pop; rx_full = 1'b0; end
      if (tx_push != l_push) begin
        l_push = tx_push;
        if (!stall) begin
          tx_empty = 1'b0; word = tx_wdata; pend = 1;
          dly = (fix_dly != 0) ? fix_dly : int'($urandom_range(4, 7));
        end
      end else if (pend) begin
        dly--;
        if (dly == 0) begin rx_rdata = word; rx_full = 1'b1; tx_empty = 1'b1; pend = 0; end
      end
    end
  end

  // Downstream sink.
  initial begin
    int hold;
    hold = 0; m_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bp_arm && m_valid) begin bp_arm = 0; hold = 10; end
      if (hold > 0) begin m_ready = 1'b0; hold--; end
      else m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic l_push, l_pop, l_txc, l_rxc, prev_stall;
    logic signed [DMSB:0] prev_d;
    l_push = 0; l_pop = 0; l_txc = 0; l_rxc = 0; prev_stall = 0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        l_push = 0; l_pop = 0; l_txc = 0; l_rxc = 0; prev_stall = 0;
        continue;
      end
      if (tx_push != l_push) begin push_cnt++; l_push = tx_push; end
      if (rx_pop != l_pop) begin pop_cnt++; l_pop = rx_pop; end
      if (tx_clear != l_txc) begin txc_cnt++; l_txc = tx_clear; end
      if (rx_clear != l_rxc) begin rxc_cnt++; l_rxc = rx_clear; end
      if (done) done_cnt++;
      if (sdm_setn) begin setn_hi++; if (!busy) setn_bad++; end
      if (prev_stall) begin
        check("m_valid_held", int'(m_valid), 1);
        check("m_data_held", int'(m_data), int'(prev_d));
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("m_unexpected_word", 1, 0);
        else check("m_data_order", int'(m_data), int'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
    end
  end

  task automatic snap();
    #1;
    s_push = push_cnt; s_pop = pop_cnt; s_done = done_cnt; s_out = out_cnt;
    s_txc = txc_cnt; s_rxc = rxc_cnt; s_setn = setn_hi;
  endtask

  task automatic do_start(input int l, input bit ab);
    @(negedge clk);
    start = 1'b1; abort = ab; len = LMSB'(l);
    if (!ab && l != 0) exp_err = 0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  // Offer one sample; the expected response is queued when the handshake is seen.
  task automatic feed(input logic signed [DMSB:0] d);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && t < 300) begin @(negedge clk); t++; end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    else exp_q.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 500) begin @(negedge clk); cyc++; end
    if (busy) check("idle_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic normal_end(input int n);
    int cyc;
    wait_idle(cyc);
    check("push_count", push_cnt - s_push, n);
    check("pop_count", pop_cnt - s_pop, n);
    check("out_count", out_cnt - s_out, n);
    check("done_count", done_cnt - s_done, 1);
    check("clears", (txc_cnt - s_txc) + (rxc_cnt - s_rxc), 0);
    check("err_after_burst", int'(err), exp_err);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int cyc, n;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_setn", int'(sdm_setn), 0);
    check("rst_toggles", int'({tx_push, tx_clear, rx_pop, rx_clear}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_done_err", int'({done, err}), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // len=4 with fixed samples
    smp = '{4'sd1, -4'sd2, 4'sd3, -4'sd4};
    snap(); do_start(4, 0);
    for (int i = 0; i < 4; i++) feed(smp[i]);
    normal_end(4);
    check("setn_high_in_burst", int'(setn_hi > s_setn), 1);
    check("setn_low_after", int'(sdm_setn), 0);

    // len=2 with downstream stalled for 10 cycles on the first word
    rand_ready = 0; bp_arm = 1;
    snap(); do_start(2, 0);
    feed(4'sd5);
    cyc = 0;
    while (!m_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check("bp_m_valid_seen", int'(m_valid), 1);
    n = push_cnt;
    repeat (9) @(negedge clk); #1;
    check("bp_no_second_push", push_cnt, n);
    check("bp_m_valid_still", int'(m_valid), 1);
    feed(-4'sd7);
    normal_end(2);
    rand_ready = 1;

    // random bursts
    for (int b = 0; b < 4; b++) begin
      n = int'($urandom_range(1, 6));
      snap(); do_start(n, 0);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        feed(DMSB'($urandom));
      end
      normal_end(n);
    end

    // len=0: done one cycle after start, nothing else
    snap();
    @(negedge clk); start = 1'b1; len = '0;
    @(negedge clk); start = 1'b0;
    check("len0_done", int'(done), 1);
    check("len0_busy", int'(busy), 0);
    @(negedge clk); #1;
    check("len0_done_once", done_cnt - s_done, 1);
    check("len0_no_push", push_cnt - s_push, 0);
    check("len0_setn_never", setn_hi - s_setn, 0);

    // start+abort together
    snap(); do_start(3, 1);
    check("start_abort_busy", int'(busy), 0);
    @(negedge clk); #1;
    check("start_abort_idle", int'(busy) + (done_cnt - s_done), 0);

    // abort in CAPT during the 3rd sample of len=8
    fix_dly = 12;
    snap(); do_start(8, 0);
    for (int i = 0; i < 3; i++) feed(DMSB'(i + 1));
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_idle_next", int'(busy), 0);
    check("abort_m_valid", int'(m_valid), 0);
    @(negedge clk); #1;
    check("abort_txclear", txc_cnt - s_txc, 1);
    check("abort_rxclear", rxc_cnt - s_rxc, 1);
    check("abort_no_done", done_cnt - s_done, 0);
    check("abort_err", int'(err), 0);
    check("abort_outputs", out_cnt - s_out, 2);
    check("abort_inflight", exp_q.size(), 1);
    exp_q.delete();
    fix_dly = 0;
    repeat (20) @(negedge clk);
    snap(); do_start(2, 0);
    feed(-4'sd8); feed(4'sd7);
    normal_end(2);

    // watchdog: SDM never accepts the word
    stall = 1;
    snap(); do_start(3, 0);
    feed(4'sd2);
    wait_idle(cyc);
    check("wdog_window", int'(cyc >= TMO && cyc <= TMO + 4), 1);
    check("wdog_err", int'(err), 1);
    check("wdog_txclear", txc_cnt - s_txc, 1);
    check("wdog_rxclear", rxc_cnt - s_rxc, 1);
    check("wdog_no_done", done_cnt - s_done, 0);
    check("wdog_setn", int'(sdm_setn), 0);
    check("wdog_one_push", push_cnt - s_push, 1);
    exp_q.delete();

    check("setn_outside_burst", setn_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
